// File: rtl/tetris_pkg.sv
// Shared types and constants for the tetromino piece queue.
//   piece_t        : 3-bit tetromino IDs (I..L) plus the NONE marker (7)
//   PIECE_COUNT    : number of real tetrominoes (7)
//   PIECE_NONE     : empty-slot / no-history marker
//   queue_state_t  : IDLE / FILL / READY states of the queue controller
package tetris_pkg;

    typedef enum logic [2:0] {
        P_I    = 3'd0,
        P_O    = 3'd1,
        P_T    = 3'd2,
        P_S    = 3'd3,
        P_Z    = 3'd4,
        P_J    = 3'd5,
        P_L    = 3'd6,
        P_NONE = 3'd7
    } piece_t;

    localparam int         PIECE_COUNT = 7;
    localparam logic [2:0] PIECE_NONE  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } queue_state_t;

endpackage

// File: rtl/piece_roll.sv
// NES-style piece generator, purely combinational.
//   random_state : 32-bit RNG word; bits [2:0] are the roll, [10:8] the reroll seed
//   last_gen     : last generated piece (PIECE_NONE when there is no history)
//   piece        : generated piece ID, always 0..6
// A roll of 7 or a repeat of last_gen is rerolled once to (r2 + prev) mod 7;
// the reroll is final even if it repeats the previous piece.
module piece_roll
    import tetris_pkg::*;
(
    input  logic [31:0] random_state,
    input  logic [2:0]  last_gen,
    output logic [2:0]  piece
);

    logic [2:0] w_roll;
    logic [2:0] w_r2;
    logic [2:0] w_prev;
    logic [3:0] w_sum;
    logic [3:0] w_mod;
    logic       w_reroll;
    logic       w_unused;

    assign w_roll   = random_state[2:0];
    assign w_r2     = random_state[10:8];
    // With no history the reroll offset is zero.
    assign w_prev   = (last_gen == PIECE_NONE) ? 3'd0 : last_gen;
    // Sum is at most 7 + 6 = 13, so a single conditional subtract is a full mod 7.
    assign w_sum    = {1'b0, w_r2} + {1'b0, w_prev};
    assign w_mod    = (w_sum >= 4'(PIECE_COUNT)) ? (w_sum - 4'(PIECE_COUNT)) : w_sum;
    assign w_reroll = (w_roll == PIECE_NONE) || (w_roll == last_gen);
    assign piece    = w_reroll ? w_mod[2:0] : w_roll;

    assign w_unused = ^{random_state[31:11], random_state[7:3]};

endmodule

// File: rtl/piece_queue.sv
// Tetromino preview queue fed by the hardware RNG.
//   clk          : system clock
//   reset        : synchronous active-high reset
//   random_state : fresh RNG word each cycle
//   start        : pulse; flush the queue and refill it (wins over piece_req)
//   piece_req    : consume the head piece (honoured only while piece_valid)
//   piece_valid  : head piece is valid (state READY)
//   piece_out    : head piece ID (entry 0)
//   preview      : whole queue, entry i at bits [3i+2:3i], entry 0 is the head
//   busy         : high while the queue is being filled
//   piece_stats  : (only with PIECE_STATS_EN) seven saturating 16-bit pop
//                  counters, counter k at bits [16k+15:16k]
// Optional feature macro: PIECE_STATS_EN.
// All outputs decode registered state; piece_req never reaches piece_out
// combinationally.
module piece_queue
    import tetris_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4
)
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              random_state,
    input  logic                     start,
    input  logic                     piece_req,
    output logic                     piece_valid,
    output logic [2:0]               piece_out,
    output logic [3*QUEUE_DEPTH-1:0] preview,
    output logic                     busy
`ifdef PIECE_STATS_EN
    ,
    output logic [7*16-1:0]          piece_stats
`endif
);

    localparam int IDX_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    queue_state_t             r_state;
    queue_state_t             w_state_next;
    logic [IDX_W-1:0]         r_wr_idx;
    logic [2:0]               r_last_gen;
    logic [3*QUEUE_DEPTH-1:0] w_entries;
    logic [2:0]               w_gen;
    logic                     w_fill_wr;
    logic                     w_pop;
    logic                     w_fill_last;

    piece_roll u_roll (
        .random_state (random_state),
        .last_gen     (r_last_gen),
        .piece        (w_gen)
    );

    // start overrides any write or pop in the same cycle.
    assign w_fill_wr   = (r_state == FILL) && !start;
    assign w_pop       = (r_state == READY) && piece_req && !start;
    assign w_fill_last = (r_wr_idx == IDX_W'(QUEUE_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = FILL;
        end else begin
            case (r_state)
                FILL:    if (w_fill_last) w_state_next = READY;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || start) begin
            r_wr_idx   <= '0;
            r_last_gen <= PIECE_NONE;
        end else begin
            if (w_fill_wr) begin
                r_wr_idx <= r_wr_idx + 1'b1;
            end
            if (w_fill_wr || w_pop) begin
                r_last_gen <= w_gen;
            end
        end
    end

    // Queue entries: written in order during FILL, shifted toward the head
    // on a pop with the tail refilled from the generator.
    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
            logic [2:0] r_entry;
            logic [2:0] w_shift_in;

            if (gi == QUEUE_DEPTH - 1) begin : g_tail
                assign w_shift_in = w_gen;
            end else begin : g_body
                assign w_shift_in = w_entries[3*(gi+1) +: 3];
            end

            always_ff @(posedge clk) begin
                if (reset || start) begin
                    r_entry <= PIECE_NONE;
                end else if (w_fill_wr && (r_wr_idx == IDX_W'(gi))) begin
                    r_entry <= w_gen;
                end else if (w_pop) begin
                    r_entry <= w_shift_in;
                end
            end

            assign w_entries[3*gi +: 3] = r_entry;
        end
    endgenerate

    assign preview     = w_entries;
    assign piece_out   = w_entries[2:0];
    assign piece_valid = (r_state == READY);
    assign busy        = (r_state == FILL);

`ifdef PIECE_STATS_EN
    generate
        for (genvar gi = 0; gi < PIECE_COUNT; gi++) begin : g_stat
            logic [15:0] r_count;

            always_ff @(posedge clk) begin
                if (reset || start) begin
                    r_count <= '0;
                end else if (w_pop && (w_entries[2:0] == 3'(gi)) && (r_count != 16'hFFFF)) begin
                    r_count <= r_count + 16'd1;
                end
            end

            assign piece_stats[16*gi +: 16] = r_count;
        end
    endgenerate
`endif

endmodule
